// File: rtl/magnetron_cook_controller_pkg.sv
// Shared types for the magnetron cook controller slice.
// State encoding and BCD digit width.
package magnetron_cook_controller_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/magnetron_cook_controller_if.sv
// Keypad/button/status bundle of the cook controller.
// master: panel side (drives buttons/keys); slave: controller.
interface magnetron_cook_controller_if;
  import magnetron_cook_controller_pkg::*;

  logic               startn;
  logic               stopn;
  logic               clearn;
  logic               door_closed;
  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               magnetron_on;
  logic [7:0]         min_bcd;
  logic [7:0]         sec_bcd;
  logic               timer_done;
  logic               done_pulse;
  logic [1:0]         state;

  modport master (
    output startn, stopn, clearn, door_closed,
    output key_valid, key_digit,
    input  magnetron_on, min_bcd, sec_bcd,
    input  timer_done, done_pulse, state
  );

  modport slave (
    input  startn, stopn, clearn, door_closed,
    input  key_valid, key_digit,
    output magnetron_on, min_bcd, sec_bcd,
    output timer_done, done_pulse, state
  );

endinterface

// File: rtl/mmss_bcd_countdown.sv
// Four-digit BCD MM:SS register: shift-load, 1 s decrement, clear.
// Ports: clr/load/dec controls, digit in, min/sec out, zero flags.
module mmss_bcd_countdown
  import magnetron_cook_controller_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               load,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] digit,
  output logic [7:0]         min_bcd,
  output logic [7:0]         sec_bcd,
  output logic               is_zero,
  output logic               dec_zero
);

  localparam logic [DIGIT_W-1:0] ONE  = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] FIVE = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(9);

  // q[3]=min_hi q[2]=min_lo q[1]=sec_hi q[0]=sec_lo
  logic [3:0][DIGIT_W-1:0] q;
  logic [3:0][DIGIT_W-1:0] q_dec;

  always_comb begin
    q_dec = q;
    if (q[0] != '0) begin
      q_dec[0] = q[0] - ONE;
    end else if (q[1] != '0) begin
      q_dec[1] = q[1] - ONE;
      q_dec[0] = NINE;
    end else begin
      q_dec[1] = FIVE;
      q_dec[0] = NINE;
      if (q[2] != '0) begin
        q_dec[2] = q[2] - ONE;
      end else begin
        q_dec[3] = q[3] - ONE;
        q_dec[2] = NINE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= {q[2:0], digit};
    else if (dec)  q <= q_dec;
  end

  assign min_bcd  = {q[3], q[2]};
  assign sec_bcd  = {q[1], q[0]};
  assign is_zero  = (q == '0);
  assign dec_zero = (q_dec == '0);

endmodule

// File: rtl/magnetron_cook_controller.sv
// Cook sequencer: FSM, 1 s prescaler, button edges, registered outputs.
// Ports: clk, resetn, bus (slave) carrying buttons, keys and status.
module magnetron_cook_controller
  import magnetron_cook_controller_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic                        clk,
  input  logic                        resetn,
  magnetron_cook_controller_if.slave  bus
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

  state_t        st_q, st_d;
  logic [PW-1:0] pre_q;
  logic          startn_q, stopn_q;
  logic          start_ev, stop_ev, tick, key_ok;
  logic          pre_clr, pre_inc;
  logic          t_clr, t_load, t_dec;
  logic          is_zero, dec_zero;

  assign start_ev = startn_q & ~bus.startn;
  assign stop_ev  = stopn_q & ~bus.stopn;
  assign tick     = (pre_q == PRE_MAX);
  assign key_ok   = bus.key_valid &&
                    (bus.key_digit <= DIGIT_W'(9));

  always_comb begin
    st_d    = st_q;
    pre_clr = 1'b0;
    pre_inc = 1'b0;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    if (!bus.clearn) begin
      st_d    = ST_IDLE;
      pre_clr = 1'b1;
      t_clr   = 1'b1;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          t_load = key_ok;
          if (start_ev && bus.door_closed && !is_zero)
            st_d = ST_COOKING;
        end
        ST_COOKING: begin
          // pause holds time and prescaler, even on a tick
          if (!bus.door_closed || stop_ev) begin
            st_d = ST_PAUSED;
          end else if (tick) begin
            pre_clr = 1'b1;
            t_dec   = 1'b1;
            if (dec_zero) st_d = ST_DONE;
          end else begin
            pre_inc = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!bus.door_closed) begin
            st_d = ST_PAUSED;
          end else if (stop_ev) begin
            st_d    = ST_IDLE;
            pre_clr = 1'b1;
            t_clr   = 1'b1;
          end else if (start_ev) begin
            st_d = ST_COOKING;
          end
        end
        ST_DONE: begin
          if (!bus.door_closed || start_ev)
            st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q             <= ST_IDLE;
      pre_q            <= '0;
      startn_q         <= 1'b1;
      stopn_q          <= 1'b1;
      bus.magnetron_on <= 1'b0;
      bus.timer_done   <= 1'b0;
      bus.done_pulse   <= 1'b0;
    end else begin
      st_q     <= st_d;
      startn_q <= bus.startn;
      stopn_q  <= bus.stopn;
      if (pre_clr)      pre_q <= '0;
      else if (pre_inc) pre_q <= pre_q + PW'(1);
      // outputs follow the next state so they align with st_q
      bus.magnetron_on <= (st_d == ST_COOKING);
      bus.timer_done   <= (st_d == ST_DONE);
      bus.done_pulse   <= (st_d == ST_DONE) &&
                          (st_q != ST_DONE);
    end
  end

  assign bus.state = st_q;

  mmss_bcd_countdown u_time (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (t_clr),
    .load     (t_load),
    .dec      (t_dec),
    .digit    (bus.key_digit),
    .min_bcd  (bus.min_bcd),
    .sec_bcd  (bus.sec_bcd),
    .is_zero  (is_zero),
    .dec_zero (dec_zero)
  );

endmodule

// File: tb/tb_magnetron_cook_controller.sv
// Self-checking bench for magnetron_cook_controller.
// Directed plan plus random stimulus against a minute/second model.
module tb_magnetron_cook_controller;

  localparam int CPS = 4;

  logic clk;
  logic resetn;
  int   errs;
  int   checks;

  magnetron_cook_controller_if bus ();

  magnetron_cook_controller #(
    .CLK_PER_SEC (CPS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: time as decimal minutes/seconds
  int m_st;
  int m_pre;
  int m_min;
  int m_sec;
  bit m_dp;
  bit m_sq;
  bit m_pq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_pre = 0;
    m_min = 0;
    m_sec = 0;
    m_dp  = 0;
    m_sq  = 1;
    m_pq  = 1;
  endtask

  task automatic model_step();
    bit sev, pev;
    int ns;
    sev = m_sq & ~bus.startn;
    pev = m_pq & ~bus.stopn;
    ns  = m_st;
    if (!bus.clearn) begin
      ns = 0; m_min = 0; m_sec = 0; m_pre = 0;
    end else begin
      case (m_st)
        0: begin
          if (sev && bus.door_closed &&
              (m_min + m_sec) != 0)
            ns = 1;
          if (bus.key_valid && bus.key_digit < 10) begin
            m_min = (m_min % 10) * 10 + m_sec / 10;
            m_sec = (m_sec % 10) * 10 + int'(bus.key_digit);
          end
        end
        1: begin
          if (!bus.door_closed || pev) begin
            ns = 2;
          end else if (m_pre == CPS - 1) begin
            m_pre = 0;
            if (m_sec > 0) m_sec--;
            else begin m_min--; m_sec = 59; end
            if (m_min == 0 && m_sec == 0) ns = 3;
          end else begin
            m_pre++;
          end
        end
        2: begin
          if (bus.door_closed) begin
            if (pev) begin
              ns = 0; m_min = 0; m_sec = 0; m_pre = 0;
            end else if (sev) begin
              ns = 1;
            end
          end
        end
        default: begin
          if (!bus.door_closed || sev) ns = 0;
        end
      endcase
    end
    m_dp = (ns == 3) && (m_st != 3);
    m_st = ns;
    m_sq = bus.startn;
    m_pq = bus.stopn;
  endtask

  task automatic compare_all();
    chk("state", 32'(bus.state), 32'(m_st));
    chk("mag", 32'(bus.magnetron_on), 32'(m_st == 1));
    chk("min", 32'(bus.min_bcd), 32'(bcd(m_min)));
    chk("sec", 32'(bus.sec_bcd), 32'(bcd(m_sec)));
    chk("tdone", 32'(bus.timer_done), 32'(m_st == 3));
    chk("dpulse", 32'(bus.done_pulse), 32'(m_dp));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic press_start();
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
  endtask

  task automatic press_stop();
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
  endtask

  task automatic do_clear();
    bus.clearn = 1'b0;
    step();
    bus.clearn = 1'b1;
  endtask

  initial begin
    errs            = 0;
    checks          = 0;
    resetn          = 1'b0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;
    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    resetn = 1'b1;

    // 1: 00:03 cook to completion
    load4(4'd0, 4'd0, 4'd0, 4'd3);
    press_start();
    chk("t1_mag_on", 32'(bus.magnetron_on), 32'd1);
    run(4);
    chk("t1_sec2", 32'(bus.sec_bcd), 32'h02);
    run(8);
    chk("t1_done", 32'(bus.state), 32'd3);
    chk("t1_pulse", 32'(bus.done_pulse), 32'd1);
    chk("t1_mag_off", 32'(bus.magnetron_on), 32'd0);
    step();
    chk("t1_pulse_once", 32'(bus.done_pulse), 32'd0);
    press_start();
    chk("t1_exit", 32'(bus.state), 32'd0);

    // 2: minute borrow and ten-second borrow
    load4(4'd0, 4'd1, 4'd0, 4'd0);
    press_start();
    run(4);
    chk("t2_min", 32'(bus.min_bcd), 32'h00);
    chk("t2_sec59", 32'(bus.sec_bcd), 32'h59);
    do_clear();
    load4(4'd0, 4'd0, 4'd1, 4'd0);
    press_start();
    run(4);
    chk("t2_sec09", 32'(bus.sec_bcd), 32'h09);
    do_clear();

    // 3: door open mid-second, resume keeps prescaler
    load4(4'd0, 4'd0, 4'd0, 4'd5);
    press_start();
    run(2);
    bus.door_closed = 1'b0;
    step();
    chk("t3_paused", 32'(bus.state), 32'd2);
    chk("t3_mag", 32'(bus.magnetron_on), 32'd0);
    run(3);
    chk("t3_frozen", 32'(bus.sec_bcd), 32'h05);
    bus.door_closed = 1'b1;
    step();
    press_start();
    chk("t3_resume", 32'(bus.state), 32'd1);
    step();
    chk("t3_no_tick", 32'(bus.sec_bcd), 32'h05);
    step();
    chk("t3_tick", 32'(bus.sec_bcd), 32'h04);
    do_clear();

    // 4: stop pauses, second stop clears, zero start ignored
    load4(4'd0, 4'd0, 4'd0, 4'd9);
    press_start();
    step();
    press_stop();
    chk("t4_paused", 32'(bus.state), 32'd2);
    step();
    press_stop();
    chk("t4_idle", 32'(bus.state), 32'd0);
    chk("t4_zero", 32'({bus.min_bcd, bus.sec_bcd}), 32'h0);
    press_start();
    chk("t4_zero_start", 32'(bus.state), 32'd0);

    // 5: door-open start ignored; clear beats tick
    load4(4'd0, 4'd0, 4'd0, 4'd7);
    bus.door_closed = 1'b0;
    press_start();
    chk("t5_door_open", 32'(bus.state), 32'd0);
    bus.door_closed = 1'b1;
    step();
    press_start();
    for (int i = 0; i < 8 && m_pre != CPS - 1; i++) step();
    chk("t5_at_tick", 32'(m_pre), 32'(CPS - 1));
    do_clear();
    chk("t5_clr_state", 32'(bus.state), 32'd0);
    chk("t5_clr_time", 32'({bus.min_bcd, bus.sec_bcd}), 32'h0);

    // 6: asynchronous reset mid-cook, invalid key digit
    load4(4'd0, 4'd0, 4'd0, 4'd9);
    press_start();
    run(2);
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_state", 32'(bus.state), 32'd0);
    chk("t6_mag", 32'(bus.magnetron_on), 32'd0);
    chk("t6_time", 32'({bus.min_bcd, bus.sec_bcd}), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    key(4'd5);
    key(4'hC);
    chk("t6_bad_key", 32'(bus.sec_bcd), 32'h05);
    do_clear();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bus.startn = ($urandom_range(0, 3) != 0);
      bus.stopn  = ($urandom_range(0, 11) != 0);
      bus.clearn = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 39) == 0)
        bus.door_closed = ~bus.door_closed;
      bus.key_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0)
        bus.key_digit = 4'($urandom_range(0, 15));
      else
        bus.key_digit = 4'($urandom_range(0, 2));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
